// File: rtl/skyhop_pkg.sv
// rtl/skyhop_pkg.sv - shared encodings for the SkyHop frame update scheduler
// Holds the scheduler state encoding, the update stage indices and the
// default per-stage watchdog limit.
package skyhop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SWAP  = 2'd3
    } state_t;

    localparam int unsigned STG_INPUT    = 0;
    localparam int unsigned STG_PLAYER   = 1;
    localparam int unsigned STG_PLATFORM = 2;
    localparam int unsigned STG_COLLIDE  = 3;

    localparam int TIMEOUT_CYC_DEF = 65535;

endpackage

// File: rtl/frame_update_scheduler_if.sv
// rtl/frame_update_scheduler_if.sv - scheduler <-> VGA timing / game-logic signal bundle
// Signals:
//   vs_in        vsync from the VGA timing generator
//   stage_done   per-stage completion, one bit per stage
//   clr_flags    synchronous clear of the sticky flags
//   stage_start  one-hot one-cycle stage start pulse
//   render_swap  one-cycle pulse after the last stage completes
//   busy         scheduler not idle
//   overrun      sticky: vsync edge arrived while busy
//   timeout      sticky: a stage watchdog abort occurred
//   fault_stage  index of the stage that timed out
//   frame_cnt    count of completed frames
// Modports: master = scheduler side, slave = environment side.
interface frame_update_scheduler_if #(
    parameter int N_STAGES    = 4,
    parameter int FRAME_CNT_W = 16
);
    logic                   vs_in;
    logic [N_STAGES-1:0]    stage_done;
    logic                   clr_flags;
    logic [N_STAGES-1:0]    stage_start;
    logic                   render_swap;
    logic                   busy;
    logic                   overrun;
    logic                   timeout;
    logic [2:0]             fault_stage;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  vs_in, stage_done, clr_flags,
        output stage_start, render_swap, busy, overrun, timeout, fault_stage, frame_cnt
    );

    modport slave (
        output vs_in, stage_done, clr_flags,
        input  stage_start, render_swap, busy, overrun, timeout, fault_stage, frame_cnt
    );
endinterface

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - registered vsync with polarity-aware active-edge pulse
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   sig          input level (same clock domain)
//   edge_pulse   high the cycle sig becomes active
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic edge_pulse
);
    localparam logic INACTIVE = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic sig_q;

    // Resetting to the inactive level means an idle vsync after reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= INACTIVE;
        end else begin
            sig_q <= sig;
        end
    end

    assign edge_pulse = (sig_q == INACTIVE) && (sig != INACTIVE);
endmodule

// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - per-frame sequencer for the SkyHop game-logic update stages
// On each active vsync edge, starts each stage in order, waits for its done,
// then issues a one-cycle render swap and counts the frame.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        frame_update_scheduler_if.master (vsync, stage handshakes, flags, counters)
// Optional feature: define WATCHDOG_EN to abort a stage that does not answer within
// TIMEOUT_CYC cycles of WAIT (sets timeout/fault_stage, no swap).
module frame_update_scheduler
    import skyhop_pkg::*;
#(
    parameter int N_STAGES      = 4,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF,
    parameter int FRAME_CNT_W   = 16
) (
    input logic                      clk,
    input logic                      rst,
    frame_update_scheduler_if.master bus
);
    localparam logic [2:0]          LAST_IDX = 3'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0] ONE      = N_STAGES'(1);

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [N_STAGES-1:0]    sel;
    logic                   done_sel;
    logic                   vs_edge;
    logic                   wd_fire;
    logic                   overrun_q;
    logic [FRAME_CNT_W-1:0] frame_q;

    sync_edge_detect #(.ACTIVE_LOW(VS_ACTIVE_LOW != 0)) u_vs_edge (
        .clk        (clk),
        .rst        (rst),
        .sig        (bus.vs_in),
        .edge_pulse (vs_edge)
    );

    // One-hot of the current stage; masking stage_done with it ignores other stages' done.
    assign sel      = ONE << idx_q;
    assign done_sel = |(bus.stage_done & sel);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        bus.stage_start = '0;
        bus.render_swap = 1'b0;
        case (state_q)
            IDLE: begin
                if (vs_edge) begin
                    state_d = START;
                    idx_d   = '0;
                end
            end
            START: begin
                bus.stage_start = sel;
                state_d         = WAIT;
            end
            WAIT: begin
                if (done_sel) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SWAP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = START;
                    end
                end else if (wd_fire) begin
                    state_d = IDLE;
                end
            end
            SWAP: begin
                bus.render_swap = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == SWAP) begin
                frame_q <= frame_q + 1'b1;
            end
            // Later assignment wins: a new overrun beats a same-cycle clear.
            if (bus.clr_flags) begin
                overrun_q <= 1'b0;
            end
            if (vs_edge && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.frame_cnt = frame_q;

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
    logic [2:0]      fault_q;

    // Fires on the TIMEOUT_CYC-th WAIT cycle without done; done in that cycle still wins.
    assign wd_fire = (state_q == WAIT) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
            fault_q   <= '0;
        end else begin
            if (state_q == START) begin
                wd_q <= '0;
            end else if (state_q == WAIT) begin
                wd_q <= wd_q + 1'b1;
            end
            if (bus.clr_flags) begin
                timeout_q <= 1'b0;
            end
            if (wd_fire && !done_sel) begin
                timeout_q <= 1'b1;
                fault_q   <= idx_q;
            end
        end
    end

    assign bus.timeout     = timeout_q;
    assign bus.fault_stage = fault_q;
`else
    logic unused_timeout;

    assign wd_fire         = 1'b0;
    assign bus.timeout     = 1'b0;
    assign bus.fault_stage = 3'd0;
    assign unused_timeout  = (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb/tb_frame_update_scheduler.sv - scoreboard bench for frame_update_scheduler
module tb_frame_update_scheduler;
    import skyhop_pkg::*;

    localparam int SWAP_EV = 99;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_update_scheduler_if #(.N_STAGES(4), .FRAME_CNT_W(16)) bus ();
    frame_update_scheduler_if #(.N_STAGES(4), .FRAME_CNT_W(2))  sbus ();

    frame_update_scheduler #(
        .N_STAGES(4), .VS_ACTIVE_LOW(1), .TIMEOUT_CYC(20), .FRAME_CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter twin sharing all stimulus, used to observe frame_cnt wrap.
    frame_update_scheduler #(
        .N_STAGES(4), .VS_ACTIVE_LOW(1), .TIMEOUT_CYC(20), .FRAME_CNT_W(2)
    ) dut_w2 (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    logic [3:0] resp_done;
    logic [3:0] inj_done;
    logic [3:0] resp_en;
    int         resp_cnt;
    int         resp_idx;

    assign bus.stage_done  = resp_done | inj_done;
    assign sbus.vs_in      = bus.vs_in;
    assign sbus.stage_done = bus.stage_done;
    assign sbus.clr_flags  = bus.clr_flags;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int exp_q[$];
    int frame_exp_q[$];
    int frames;
    bit frame_chk_pend;
    int frame_chk_val;

    // Monitor + stage responder: each enabled stage answers done 3 cycles after its start.
    always @(negedge clk) begin
        int obs;
        int e;
        if (frame_chk_pend) begin
            chk("frame_cnt", bus.frame_cnt, frame_chk_val);
            chk("frame_cnt_w2", sbus.frame_cnt, frame_chk_val % 4);
            chk("busy_after_swap", bus.busy, 0);
            frame_chk_pend = 1'b0;
        end
        if (rst) begin
            resp_cnt  = 0;
            resp_done = '0;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            resp_done = (resp_cnt == 0) ? (4'b0001 << resp_idx) : 4'b0000;
        end else begin
            resp_done = '0;
        end
        if (bus.stage_start != 0 || bus.render_swap) begin
            obs = SWAP_EV;
            if (!bus.render_swap) begin
                for (int i = 0; i < 4; i++) if (bus.stage_start[i]) obs = i;
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_event", obs, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("event_order", obs, e);
            end
            if (bus.render_swap) begin
                if (frame_exp_q.size() != 0) begin
                    frame_chk_val  = frame_exp_q.pop_front();
                    frame_chk_pend = 1'b1;
                end
            end else begin
                chk("start_onehot", bus.stage_start, 32'd1 << obs);
                if (resp_en[obs]) begin
                    resp_cnt = 3;
                    resp_idx = obs;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vs_pulse();
        bus.vs_in = 1'b0;
        tick(2);
        bus.vs_in = 1'b1;
    endtask

    task automatic expect_frame();
        exp_q.push_back(STG_INPUT);
        exp_q.push_back(STG_PLAYER);
        exp_q.push_back(STG_PLATFORM);
        exp_q.push_back(STG_COLLIDE);
        exp_q.push_back(SWAP_EV);
        frames++;
        frame_exp_q.push_back(frames);
    endtask

    task automatic wait_swap(input string tag);
        int n = 0;
        while (!bus.render_swap && n < 200) begin
            tick();
            n++;
        end
        chk(tag, (n < 200), 1);
        tick(2);
    endtask

    task automatic wait_start(input string tag, input int k);
        int n = 0;
        while (!bus.stage_start[k] && n < 200) begin
            tick();
            n++;
        end
        chk(tag, (n < 200), 1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.vs_in      = 1'b1;
        bus.clr_flags  = 1'b0;
        inj_done       = '0;
        resp_en        = 4'b1111;
        resp_done      = '0;
        resp_cnt       = 0;
        resp_idx       = 0;
        frames         = 0;
        frame_chk_pend = 1'b0;
        tick(3);
        chk("rst_busy", bus.busy, 0);
        chk("rst_start", bus.stage_start, 0);
        chk("rst_swap", bus.render_swap, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_fault", bus.fault_stage, 0);
        chk("rst_frame", bus.frame_cnt, 0);
        rst = 1'b0;
        tick(3);
        chk("no_false_edge", bus.busy, 0);

        // 1: one full frame
        expect_frame();
        vs_pulse();
        chk("busy_in_frame", bus.busy, 1);
        wait_swap("t1_swap");

        // 2: vsync edge while stage 1 waits -> overrun, sequence completes, no retrigger
        expect_frame();
        vs_pulse();
        wait_start("t2_start1", 1);
        tick();
        vs_pulse();
        chk("overrun_set", bus.overrun, 1);
        wait_swap("t2_swap");
        tick(25);
        chk("t2_idle", bus.busy, 0);
        chk("overrun_sticky", bus.overrun, 1);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("overrun_clr", bus.overrun, 0);

        // 3: foreign done while stage 0 waits is ignored
        resp_en = 4'b1110;
        expect_frame();
        vs_pulse();
        inj_done = 4'b0100;
        tick(3);
        inj_done = 4'b0000;
        chk("t3_busy", bus.busy, 1);
        chk("t3_no_start", bus.stage_start, 0);
        tick(2);
        inj_done = 4'b0001;
        tick();
        inj_done = 4'b0000;
        resp_en  = 4'b1111;
        wait_swap("t3_swap");

        // 4: async reset while stage 2 waits
        exp_q.push_back(STG_INPUT);
        exp_q.push_back(STG_PLAYER);
        exp_q.push_back(STG_PLATFORM);
        vs_pulse();
        wait_start("t4_start2", 2);
        tick();
        rst = 1'b1;
        #1;
        chk("t4_busy", bus.busy, 0);
        chk("t4_start", bus.stage_start, 0);
        chk("t4_swap", bus.render_swap, 0);
        chk("t4_frame", bus.frame_cnt, 0);
        chk("t4_overrun", bus.overrun, 0);
        exp_q.delete();
        frame_exp_q.delete();
        frames = 0;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("t4_idle_after_rst", bus.busy, 0);
        expect_frame();
        vs_pulse();
        wait_swap("t4_restart_swap");

        // 6: frame counter wrap observed on the 2-bit twin (4 frames -> 0)
        for (int f = 0; f < 3; f++) begin
            expect_frame();
            vs_pulse();
            wait_swap("t6_swap");
        end

`ifdef WATCHDOG_EN
        // 5: stage 1 never answers -> watchdog abort after 20 WAIT cycles
        begin
            int n;
            resp_en = 4'b1101;
            exp_q.push_back(STG_INPUT);
            exp_q.push_back(STG_PLAYER);
            vs_pulse();
            wait_start("t5_start1", 1);
            n = 0;
            while (!bus.timeout && n < 60) begin
                tick();
                n++;
            end
            chk("wd_cycles", n, 21);
            chk("wd_fault", bus.fault_stage, 1);
            chk("wd_busy", bus.busy, 0);
            chk("wd_frame", bus.frame_cnt, frames);
            tick(3);
            chk("wd_sticky", bus.timeout, 1);
            bus.clr_flags = 1'b1;
            tick();
            bus.clr_flags = 1'b0;
            chk("wd_clr", bus.timeout, 0);
            resp_en = 4'b1111;
        end
`else
        chk("timeout_tied", bus.timeout, 0);
        chk("fault_tied", bus.fault_stage, 0);
`endif

        tick(5);
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
